prt_table: RTL

- Packet Reference Table responder: the storage side of the PRT method handshake that the MPD initiates.
- Buffers up to NUM_SLOTS packets of up to MAX_WORDS words each.
- Hands out free slots for writes, accepts data words, and marks a slot valid on finish.
- Streams stored words back on read, and frees slots on invalidate.
- Sits between the MPD controller and the packet-storage path.
- Every method is an EN/RDY pair: RDY is an output computed from current state; EN is an input and acts at the rising CLK edge. EN is only legal while RDY=1; the block ignores EN when RDY=0.

---
 rtl/prt_pkg.sv | 31 +++
 rtl/prt_free_finder.sv | 24 ++
 rtl/prt_table.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prt_pkg.sv
// Shared types and width helpers for the packet reference table.
package prt_pkg;

    // Write-side method state: idle or streaming words into one slot.
    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wr_state_e;

    // Read-side method state: idle or streaming beats out of one slot.
    typedef enum logic {
        R_IDLE   = 1'b0,
        R_ACTIVE = 1'b1
    } rd_state_e;

    // Width of a slot index.
    function automatic int slot_w_f(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    // Width of a word counter that must also hold MAX_WORDS itself.
    function automatic int cnt_w_f(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    // Width of a word index inside one slot (0 .. MAX_WORDS-1).
    function automatic int word_w_f(input int max_words);
        return (max_words > 1) ? $clog2(max_words) : 1;
    endfunction

endpackage

// File: rtl/prt_free_finder.sv
// Lowest-index priority encoder over the allocatable-slot mask.
module prt_free_finder
    import prt_pkg::*;
#(
    parameter  int NUM_SLOTS = 16,
    localparam int SLOT_W    = slot_w_f(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] mask,
    output logic                 found,
    output logic [SLOT_W-1:0]    slot
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        found = |mask;
        slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                slot = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/prt_table.sv
// Packet reference table: allocates slots, buffers written words,
// streams them back on read and frees slots on invalidate.
module prt_table
    import prt_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_SLOTS  = 16,
    parameter  int MAX_WORDS  = 16,
    localparam int SLOT_W     = slot_w_f(NUM_SLOTS),
    localparam int CNT_W      = cnt_w_f(MAX_WORDS)
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  EN_start_writing_prt_entry,
    output logic                  RDY_start_writing_prt_entry,
    output logic [SLOT_W-1:0]     start_writing_prt_entry,

    input  logic                  EN_write_prt_entry,
    output logic                  RDY_write_prt_entry,
    input  logic [DATA_WIDTH-1:0] write_prt_entry_data,

    input  logic                  EN_finish_writing_prt_entry,
    output logic                  RDY_finish_writing_prt_entry,

    input  logic                  EN_invalidate_prt_entry,
    output logic                  RDY_invalidate_prt_entry,
    input  logic [SLOT_W-1:0]     invalidate_prt_entry_slot,

    input  logic                  EN_start_reading_prt_entry,
    output logic                  RDY_start_reading_prt_entry,
    input  logic [SLOT_W-1:0]     start_reading_prt_entry_slot,

    input  logic                  EN_read_prt_entry,
    output logic                  RDY_read_prt_entry,
    output logic [DATA_WIDTH:0]   read_prt_entry,

    output logic                  is_prt_slot_free,
    output logic                  RDY_is_prt_slot_free
);

    localparam int WORD_W = word_w_f(MAX_WORDS);

    // Goes high on the first edge after reset release; gates every RDY.
    logic alive_reg;

    wr_state_e wr_state_reg, wr_state_next;
    rd_state_e rd_state_reg, rd_state_next;

    logic [SLOT_W-1:0] wslot_reg;
    logic [CNT_W-1:0]  wcnt_reg;
    logic [CNT_W-1:0]  wcnt_plus;

    // Read context is snapshotted at start so a concurrent invalidate
    // cannot truncate or alter a stream already in flight.
    logic [SLOT_W-1:0] rslot_reg;
    logic [CNT_W-1:0]  rptr_reg;
    logic [CNT_W-1:0]  rlen_reg;
    logic              rvalid_reg;

    logic [NUM_SLOTS-1:0] valid_reg;
    logic [CNT_W-1:0]     len_reg [NUM_SLOTS];

    // Packet storage; contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS][MAX_WORDS];

    logic w_active, r_active;
    logic [NUM_SLOTS-1:0] alloc_mask;
    logic                 free_found;
    logic [SLOT_W-1:0]    free_slot;

    logic start_w_fire, write_fire, finish_fire, inv_fire, start_r_fire, read_fire;
    logic inv_blocked;
    logic beat_empty, beat_last;
    logic [DATA_WIDTH-1:0] beat_data;

    assign w_active = alive_reg && (wr_state_reg == W_ACTIVE);
    assign r_active = alive_reg && (rd_state_reg == R_ACTIVE);

    // A slot is allocatable when it holds nothing and neither method owns it.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_alloc
        assign alloc_mask[gi] = !valid_reg[gi]
                             && !(w_active && (wslot_reg == SLOT_W'(gi)))
                             && !(r_active && (rslot_reg == SLOT_W'(gi)));
    end

    prt_free_finder #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_free_finder (
        .mask  (alloc_mask),
        .found (free_found),
        .slot  (free_slot)
    );

    // Method readiness, all forced low while in reset.
    assign RDY_start_writing_prt_entry  = alive_reg && (wr_state_reg == W_IDLE) && free_found;
    assign start_writing_prt_entry      = (alive_reg && free_found) ? free_slot : '0;
    assign RDY_write_prt_entry          = w_active && (wcnt_reg < CNT_W'(MAX_WORDS));
    assign RDY_finish_writing_prt_entry = w_active;
    assign RDY_invalidate_prt_entry     = alive_reg;
    assign RDY_start_reading_prt_entry  = alive_reg && (rd_state_reg == R_IDLE);
    assign RDY_read_prt_entry           = r_active;
    assign is_prt_slot_free             = alive_reg && free_found;
    assign RDY_is_prt_slot_free         = alive_reg;

    // An EN only counts while its RDY is high.
    assign start_w_fire = EN_start_writing_prt_entry  && RDY_start_writing_prt_entry;
    assign write_fire   = EN_write_prt_entry          && RDY_write_prt_entry;
    assign finish_fire  = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
    assign inv_fire     = EN_invalidate_prt_entry     && RDY_invalidate_prt_entry;
    assign start_r_fire = EN_start_reading_prt_entry  && RDY_start_reading_prt_entry;
    assign read_fire    = EN_read_prt_entry           && RDY_read_prt_entry;

    // The slot being written cannot be freed underneath the writer.
    assign inv_blocked = w_active && (invalidate_prt_entry_slot == wslot_reg);
    assign wcnt_plus   = wcnt_reg + CNT_W'(1);

    // Reset-release tracker.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) alive_reg <= 1'b0;
        else        alive_reg <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) wr_state_reg <= W_IDLE;
        else        wr_state_reg <= wr_state_next;
    end

    // Write FSM next-state: open on start, close on finish.
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE:   if (start_w_fire) wr_state_next = W_ACTIVE;
            W_ACTIVE: if (finish_fire)  wr_state_next = W_IDLE;
            default:  wr_state_next = W_IDLE;
        endcase
    end

    // Write cursor: latch the allocated slot and count appended words.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wslot_reg <= '0;
            wcnt_reg  <= '0;
        end else if (start_w_fire) begin
            wslot_reg <= start_writing_prt_entry;
            wcnt_reg  <= '0;
        end else if (write_fire) begin
            wcnt_reg  <= wcnt_plus;
        end
    end

    // Slot bookkeeping: invalidate first so a finish on the same slot wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_reg <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len_reg[i] <= '0;
            end
        end else begin
            if (inv_fire && !inv_blocked) begin
                valid_reg[invalidate_prt_entry_slot] <= 1'b0;
            end
            if (finish_fire) begin
                valid_reg[wslot_reg] <= 1'b1;
                len_reg[wslot_reg]   <= write_fire ? wcnt_plus : wcnt_reg;
            end
        end
    end

    // Word storage.
    always_ff @(posedge CLK) begin
        if (write_fire) begin
            mem[wslot_reg][wcnt_reg[WORD_W-1:0]] <= write_prt_entry_data;
        end
    end

    // Read FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rd_state_reg <= R_IDLE;
        else        rd_state_reg <= rd_state_next;
    end

    // Read FSM next-state: open on start, close when the last beat is taken.
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:   if (start_r_fire)            rd_state_next = R_ACTIVE;
            R_ACTIVE: if (read_fire && beat_last)  rd_state_next = R_IDLE;
            default:  rd_state_next = R_IDLE;
        endcase
    end

    // Read cursor: snapshot slot status at start, then advance per beat.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rslot_reg  <= '0;
            rptr_reg   <= '0;
            rlen_reg   <= '0;
            rvalid_reg <= 1'b0;
        end else if (start_r_fire) begin
            rslot_reg  <= start_reading_prt_entry_slot;
            rptr_reg   <= '0;
            rlen_reg   <= len_reg[start_reading_prt_entry_slot];
            rvalid_reg <= valid_reg[start_reading_prt_entry_slot];
        end else if (read_fire && !beat_last) begin
            rptr_reg   <= rptr_reg + CNT_W'(1);
        end
    end

    // Beat presentation: an invalid or empty slot yields one zero last-beat.
    always_comb begin
        beat_empty = !rvalid_reg || (rlen_reg == '0);
        beat_last  = beat_empty || (rptr_reg == (rlen_reg - CNT_W'(1)));
        beat_data  = beat_empty ? '0 : mem[rslot_reg][rptr_reg[WORD_W-1:0]];
        read_prt_entry = r_active ? {beat_last, beat_data} : '0;
    end

endmodule
